// File: rtl/vidram_arbiter_if.sv
// vidram_arbiter_if
// Bundles the three sides of the video SRAM arbiter into one port:
//   scan_*  : VGA scan reader (gate, address in; registered data, miss flag out)
//   cli_*   : drawing client command/response handshake
//   sram_*  : registered SRAM pin-driver bus
// Modports:
//   slave   : the arbiter itself
//   master  : everything around it (VGA controller, drawing FSM, pin driver)
interface vidram_arbiter_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   logic              scan_gate;
   logic [ADDR_W-1:0] scan_addr;
   logic [DATA_W-1:0] scan_data;
   logic              scan_miss;

   logic              cli_req;
   logic              cli_we;
   logic              cli_rmw;
   logic [ADDR_W-1:0] cli_addr;
   logic [DATA_W-1:0] cli_wdata;
   logic [DATA_W-1:0] cli_mask;
   logic              cli_gnt;
   logic              cli_rvalid;
   logic [DATA_W-1:0] cli_rdata;
   logic              cli_done;

   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_dout;
   logic              sram_doe;
   logic [DATA_W-1:0] sram_din;
   logic              sram_cen;
   logic              sram_oen;
   logic              sram_wen;

   modport slave (
      input  scan_gate, scan_addr,
      input  cli_req, cli_we, cli_rmw, cli_addr, cli_wdata, cli_mask,
      input  sram_din,
      output scan_data, scan_miss,
      output cli_gnt, cli_rvalid, cli_rdata, cli_done,
      output sram_addr, sram_dout, sram_doe, sram_cen, sram_oen, sram_wen
   );

   modport master (
      output scan_gate, scan_addr,
      output cli_req, cli_we, cli_rmw, cli_addr, cli_wdata, cli_mask,
      output sram_din,
      input  scan_data, scan_miss,
      input  cli_gnt, cli_rvalid, cli_rdata, cli_done,
      input  sram_addr, sram_dout, sram_doe, sram_cen, sram_oen, sram_wen
   );
endinterface

// File: rtl/vidram_arbiter.sv
// vidram_arbiter
// Single bus master for the 16-bit single-port video SRAM. The VGA scan
// reader owns the SRAM while scan_gate is high (one word per cycle); the
// drawing client gets reads, writes and, when VIDRAM_ARB_RMW_EN is defined,
// atomic read-merge-writes outside the fetch window. A started client
// transaction always runs to completion; scan_gate arriving meanwhile only
// raises scan_miss.
// Ports:
//   CLK     system clock
//   RST     asynchronous, active-high reset
//   bus     vidram_arbiter_if.slave (scan, client and SRAM pin signals)
// Parameters: ADDR_W, DATA_W, WR_CYCLES (cycles WEN held low, >= 1)
// Build option: VIDRAM_ARB_RMW_EN enables the cli_rmw / cli_mask path;
// without it requests decode on cli_we only.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | bus released (cen=1); scan wins, else client is granted
// S_SCAN      | streaming scan reads, one address per cycle
// S_RD_ADDR   | client read address on pins, oen=0
// S_RD_LATCH  | cli_rdata valid (rvalid pulse); rmw merges write word
// S_WR_SETUP  | address/data/doe stable ahead of the strobe
// S_WR_STROBE | wen=0 for WR_CYCLES cycles (down-counter)
// S_WR_HOLD   | wen released, data still driven, cli_done pulse
// S_TURN      | doe off, one quiet bus cycle before anything new
module vidram_arbiter #(
   parameter int ADDR_W    = 18,
   parameter int DATA_W    = 16,
   parameter int WR_CYCLES = 2
) (
   input logic            CLK,
   input logic            RST,
   vidram_arbiter_if.slave bus
);

   localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_RD_ADDR,
      S_RD_LATCH,
      S_WR_SETUP,
      S_WR_STROBE,
      S_WR_HOLD,
      S_TURN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wr_cnt;
   logic             req_wr;

`ifdef VIDRAM_ARB_RMW_EN
   logic              op_rmw;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mask_q;
   logic              req_rmw;

   // rmw outranks we: an rmw request always takes the read-first path
   assign req_rmw = bus.cli_rmw;
   assign req_wr  = bus.cli_we & ~bus.cli_rmw;
`else
   logic unused_rmw_inputs;

   assign unused_rmw_inputs = bus.cli_rmw ^ (^bus.cli_mask);
   assign req_wr            = bus.cli_we;
`endif

   // Grant is only possible from IDLE with the scan window closed, so the
   // command is consumed on the same edge the state leaves IDLE.
   assign bus.cli_gnt   = ~RST & (state == S_IDLE) & ~bus.scan_gate & bus.cli_req;
   assign bus.scan_miss = ~RST & bus.scan_gate & (state != S_SCAN);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state          <= S_IDLE;
         wr_cnt         <= '0;
         bus.sram_addr  <= '0;
         bus.sram_dout  <= '0;
         bus.sram_doe   <= 1'b0;
         bus.sram_cen   <= 1'b1;
         bus.sram_oen   <= 1'b1;
         bus.sram_wen   <= 1'b1;
         bus.scan_data  <= '0;
         bus.cli_rdata  <= '0;
         bus.cli_rvalid <= 1'b0;
         bus.cli_done   <= 1'b0;
`ifdef VIDRAM_ARB_RMW_EN
         op_rmw         <= 1'b0;
         wdata_q        <= '0;
         mask_q         <= '0;
`endif
      end else begin
         bus.cli_rvalid <= 1'b0;
         bus.cli_done   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.scan_gate) begin
                  state         <= S_SCAN;
                  bus.sram_addr <= bus.scan_addr;
                  bus.sram_cen  <= 1'b0;
                  bus.sram_oen  <= 1'b0;
               end else if (bus.cli_req) begin
                  bus.sram_addr <= bus.cli_addr;
                  bus.sram_cen  <= 1'b0;
`ifdef VIDRAM_ARB_RMW_EN
                  op_rmw        <= req_rmw;
                  wdata_q       <= bus.cli_wdata;
                  mask_q        <= bus.cli_mask;
`endif
                  if (req_wr) begin
                     state         <= S_WR_SETUP;
                     bus.sram_dout <= bus.cli_wdata;
                     bus.sram_doe  <= 1'b1;
                     bus.sram_oen  <= 1'b1;
                  end else begin
                     state        <= S_RD_ADDR;
                     bus.sram_oen <= 1'b0;
                  end
               end
            end

            S_SCAN: begin
               // Capture also on the exit cycle so the last presented
               // address still lands in scan_data.
               bus.scan_data <= bus.sram_din;
               if (bus.scan_gate) begin
                  bus.sram_addr <= bus.scan_addr;
               end else begin
                  state        <= S_IDLE;
                  bus.sram_cen <= 1'b1;
                  bus.sram_oen <= 1'b1;
               end
            end

            S_RD_ADDR: begin
               bus.cli_rdata  <= bus.sram_din;
               bus.cli_rvalid <= 1'b1;
               // Output drive off a cycle early so an rmw can turn the bus
               // straight into a write without overlap.
               bus.sram_oen   <= 1'b1;
               state          <= S_RD_LATCH;
            end

            S_RD_LATCH: begin
`ifdef VIDRAM_ARB_RMW_EN
               if (op_rmw) begin
                  bus.sram_dout <= (bus.cli_rdata & ~mask_q) | (wdata_q & mask_q);
                  bus.sram_doe  <= 1'b1;
                  state         <= S_WR_SETUP;
               end else begin
                  bus.sram_cen <= 1'b1;
                  state        <= S_IDLE;
               end
`else
               bus.sram_cen <= 1'b1;
               state        <= S_IDLE;
`endif
            end

            S_WR_SETUP: begin
               bus.sram_wen <= 1'b0;
               wr_cnt       <= CNT_W'(WR_CYCLES - 1);
               state        <= S_WR_STROBE;
            end

            S_WR_STROBE: begin
               if (wr_cnt == '0) begin
                  bus.sram_wen <= 1'b1;
                  bus.cli_done <= 1'b1;
                  state        <= S_WR_HOLD;
               end else begin
                  wr_cnt <= wr_cnt - 1'b1;
               end
            end

            S_WR_HOLD: begin
               bus.sram_doe <= 1'b0;
               state        <= S_TURN;
            end

            S_TURN: begin
               bus.sram_cen <= 1'b1;
               state        <= S_IDLE;
            end

            default: begin
               state        <= S_IDLE;
               bus.sram_cen <= 1'b1;
               bus.sram_oen <= 1'b1;
               bus.sram_wen <= 1'b1;
               bus.sram_doe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vidram_arbiter.sv
// tb_vidram_arbiter
// Directed bench for vidram_arbiter with a 4K-word behavioural SRAM whose
// unwritten words read as addr ^ 16'hFFFF (low address bits).
module tb_vidram_arbiter;

   logic CLK = 1'b0;
   logic RST;

   int n_chk = 0;
   int n_err = 0;

   vidram_arbiter_if bus ();

   vidram_arbiter #(.ADDR_W(18), .DATA_W(16), .WR_CYCLES(2)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;

   // behavioural SRAM
   logic [15:0] mem [0:4095];
   bit          mem_init_done;

   always @(posedge CLK) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 16'(i) ^ 16'hFFFF;
         mem_init_done <= 1'b1;
      end else if (!bus.sram_cen && !bus.sram_wen) begin
         mem[bus.sram_addr[11:0]] <= bus.sram_dout;
      end
   end

   assign bus.sram_din = (!bus.sram_cen && !bus.sram_oen) ? mem[bus.sram_addr[11:0]] : 16'h0000;

`ifdef VIDRAM_ARB_RMW_EN
   localparam int          RMW_RV_K   = 2;
   localparam int          RMW_DONE_K = 6;
   localparam logic [15:0] RMW_MEM    = 16'h1274;
`else
   localparam int          RMW_RV_K   = 0;
   localparam int          RMW_DONE_K = 4;
   localparam logic [15:0] RMW_MEM    = 16'h0070;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (!RST) chk("bus_conflict", 32'(bus.sram_doe & ~bus.sram_oen), 32'd0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int misses;

      RST           = 1'b1;
      bus.scan_gate = 1'b1;
      bus.scan_addr = '0;
      bus.cli_req   = 1'b1;
      bus.cli_we    = 1'b0;
      bus.cli_rmw   = 1'b0;
      bus.cli_addr  = '0;
      bus.cli_wdata = '0;
      bus.cli_mask  = '0;

      // reset state
      repeat (3) @(posedge CLK);
      #3;
      chk("rst_cen", 32'(bus.sram_cen), 32'd1);
      chk("rst_oen", 32'(bus.sram_oen), 32'd1);
      chk("rst_wen", 32'(bus.sram_wen), 32'd1);
      chk("rst_doe", 32'(bus.sram_doe), 32'd0);
      chk("rst_addr", 32'(bus.sram_addr), 32'd0);
      chk("rst_dout", 32'(bus.sram_dout), 32'd0);
      chk("rst_scan_data", 32'(bus.scan_data), 32'd0);
      chk("rst_rdata", 32'(bus.cli_rdata), 32'd0);
      chk("rst_gnt", 32'(bus.cli_gnt), 32'd0);
      chk("rst_rvalid", 32'(bus.cli_rvalid), 32'd0);
      chk("rst_done", 32'(bus.cli_done), 32'd0);
      chk("rst_miss", 32'(bus.scan_miss), 32'd0);
      bus.scan_gate = 1'b0;
      bus.cli_req   = 1'b0;
      RST           = 1'b0;

      // plain write, then back-to-back read at the earliest grant
      cyc();
      bus.cli_req = 1'b1; bus.cli_we = 1'b1;
      bus.cli_addr = 18'h12C00; bus.cli_wdata = 16'h0A53;
      #2;
      chk("wr_gnt", 32'(bus.cli_gnt), 32'd1);
      for (int k = 1; k <= 6; k++) begin
         cyc();
         if (k == 1) bus.cli_req = 1'b0;
         if (k == 5) begin bus.cli_req = 1'b1; bus.cli_we = 1'b0; end
         #2;
         chk($sformatf("wr_wen_k%0d", k), 32'(bus.sram_wen), (k == 2 || k == 3) ? 32'd0 : 32'd1);
         chk($sformatf("wr_done_k%0d", k), 32'(bus.cli_done), (k == 4) ? 32'd1 : 32'd0);
         chk($sformatf("wr_doe_k%0d", k), 32'(bus.sram_doe), (k <= 4) ? 32'd1 : 32'd0);
         if (k == 1) chk("wr_addr", 32'(bus.sram_addr), 32'h12C00);
         if (k == 5) chk("wr_turn_nognt", 32'(bus.cli_gnt), 32'd0);
         if (k == 6) chk("rd_gnt_earliest", 32'(bus.cli_gnt), 32'd1);
      end
      chk("wr_mem", 32'(mem[12'hC00]), 32'h0A53);
      cyc(); bus.cli_req = 1'b0; #2;
      chk("rd_rvalid_g1", 32'(bus.cli_rvalid), 32'd0);
      cyc(); #2;
      chk("rd_rvalid_g2", 32'(bus.cli_rvalid), 32'd1);
      chk("rd_rdata", 32'(bus.cli_rdata), 32'h0A53);
      cyc(); #2;
      chk("rd_rvalid_g3", 32'(bus.cli_rvalid), 32'd0);

      // scan streaming, two cycles of latency
      cyc();
      bus.scan_gate = 1'b1; bus.scan_addr = 18'd0;
      for (int j = 1; j <= 7; j++) begin
         cyc();
         bus.scan_addr = 18'(j);
         #2;
         chk($sformatf("scan_miss_j%0d", j), 32'(bus.scan_miss), 32'd0);
         chk($sformatf("scan_cen_j%0d", j), 32'(bus.sram_cen), 32'd0);
         chk($sformatf("scan_addr_j%0d", j), 32'(bus.sram_addr), 32'(j - 1));
         if (j >= 2)
            chk($sformatf("scan_data_j%0d", j), 32'(bus.scan_data), 32'(16'(j - 2) ^ 16'hFFFF));
      end
      cyc(); bus.scan_gate = 1'b0; #2;
      cyc(); #2;
      chk("scan_exit_cen", 32'(bus.sram_cen), 32'd1);
      chk("scan_last_data", 32'(bus.scan_data), 32'hFFF8);

      // simultaneous scan_gate and cli_req: scan wins
      cyc();
      bus.scan_gate = 1'b1; bus.cli_req = 1'b1; bus.cli_we = 1'b0; bus.cli_addr = 18'h12C00;
      #2;
      chk("sim_gnt_first", 32'(bus.cli_gnt), 32'd0);
      for (int j = 0; j < 3; j++) begin
         cyc(); #2;
         chk($sformatf("sim_gnt_scan%0d", j), 32'(bus.cli_gnt), 32'd0);
      end
      cyc(); bus.scan_gate = 1'b0; #2;
      chk("sim_gnt_fall", 32'(bus.cli_gnt), 32'd0);
      cyc(); #2;
      chk("sim_gnt_idle", 32'(bus.cli_gnt), 32'd1);
      cyc(); bus.cli_req = 1'b0; #2;
      cyc(); #2;
      chk("sim_rvalid", 32'(bus.cli_rvalid), 32'd1);
      chk("sim_rdata", 32'(bus.cli_rdata), 32'h0A53);

      // scan_gate rises one cycle after a write grant
      cyc();
      bus.cli_req = 1'b1; bus.cli_we = 1'b1; bus.cli_addr = 18'd5; bus.cli_wdata = 16'hBEEF;
      #2;
      chk("sw_gnt", 32'(bus.cli_gnt), 32'd1);
      chk("sw_miss_g", 32'(bus.scan_miss), 32'd0);
      misses = 0;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 1) begin bus.cli_req = 1'b0; bus.scan_gate = 1'b1; bus.scan_addr = 18'd3; end
         #2;
         if (bus.scan_miss) misses++;
         chk($sformatf("sw_miss_k%0d", k), 32'(bus.scan_miss), (k <= 6) ? 32'd1 : 32'd0);
         chk($sformatf("sw_done_k%0d", k), 32'(bus.cli_done), (k == 4) ? 32'd1 : 32'd0);
         if (k == 3) chk("sw_scan_hold", 32'(bus.scan_data), 32'hFFF8);
         if (k == 8) chk("sw_scan_data", 32'(bus.scan_data), 32'hFFFC);
      end
      chk("sw_miss_count", 32'(misses), 32'd6);
      cyc(); bus.scan_gate = 1'b0; #2;
      cyc(); #2;
      chk("sw_mem", 32'(mem[12'd5]), 32'hBEEF);

      // read-modify-write (or plain write without the option)
      cyc();
      bus.cli_req = 1'b1; bus.cli_we = 1'b1; bus.cli_addr = 18'h10; bus.cli_wdata = 16'h1234;
      #2;
      chk("pre_gnt", 32'(bus.cli_gnt), 32'd1);
      cyc(); bus.cli_req = 1'b0;
      repeat (5) cyc();
      chk("pre_mem", 32'(mem[12'h10]), 32'h1234);
      bus.cli_req = 1'b1; bus.cli_we = 1'b1; bus.cli_rmw = 1'b1;
      bus.cli_addr = 18'h10; bus.cli_mask = 16'h00F0; bus.cli_wdata = 16'h0070;
      #2;
      chk("rmw_gnt", 32'(bus.cli_gnt), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 1) begin bus.cli_req = 1'b0; bus.cli_rmw = 1'b0; end
         #2;
         chk($sformatf("rmw_rvalid_k%0d", k), 32'(bus.cli_rvalid), (k == RMW_RV_K) ? 32'd1 : 32'd0);
         chk($sformatf("rmw_done_k%0d", k), 32'(bus.cli_done), (k == RMW_DONE_K) ? 32'd1 : 32'd0);
         if (k == RMW_RV_K) chk("rmw_rdata", 32'(bus.cli_rdata), 32'h1234);
      end
      chk("rmw_mem", 32'(mem[12'h10]), 32'(RMW_MEM));

      // reset in the middle of the write strobe
      cyc();
      bus.cli_req = 1'b1; bus.cli_we = 1'b1; bus.cli_addr = 18'h20; bus.cli_wdata = 16'h5555;
      #2;
      chk("rs_gnt", 32'(bus.cli_gnt), 32'd1);
      cyc(); bus.cli_req = 1'b0;
      cyc(); #2;
      chk("rs_wen_low", 32'(bus.sram_wen), 32'd0);
      #1 RST = 1'b1;
      #1;
      chk("rs_async_wen", 32'(bus.sram_wen), 32'd1);
      chk("rs_async_doe", 32'(bus.sram_doe), 32'd0);
      cyc(); #2;
      chk("rs_wen", 32'(bus.sram_wen), 32'd1);
      chk("rs_doe", 32'(bus.sram_doe), 32'd0);
      chk("rs_cen", 32'(bus.sram_cen), 32'd1);
      chk("rs_addr", 32'(bus.sram_addr), 32'd0);
      chk("rs_done", 32'(bus.cli_done), 32'd0);
      cyc(); RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc(); #2;
         chk($sformatf("rs_post_done%0d", k), 32'(bus.cli_done), 32'd0);
         chk($sformatf("rs_post_cen%0d", k), 32'(bus.sram_cen), 32'd1);
      end
      chk("rs_mem_untouched", 32'(mem[12'h20]), 32'hFFDF);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vidram_arbiter.md
# vidram_arbiter

Owns the single-port 16-bit video SRAM and shares it between two requesters: the VGA scan reader, which has absolute priority while its gate is open, and one drawing client that issues reads, writes and (optionally) atomic read-modify-writes during blanking. It sits between the VGA controller, the drawing state machine and the SRAM pin driver. It replaces per-client address muxing and write-strobe sequencing with one registered bus master.

## Interface
Parameters:
- ADDR_W, 18, SRAM word address width
- DATA_W, 16, SRAM data width
- WR_CYCLES, 2, cycles WEN is held low per write (≥1)

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- scan_gate  in  1  VGA inside fetch window; scan port has priority
- scan_addr  in  ADDR_W  scan read address
- scan_data  out  DATA_W  scan read data, registered
- scan_miss  out  1  high each cycle scan_gate=1 while arbiter not in SCAN
- cli_req  in  1  client request, held until cli_gnt
- cli_we  in  1  1=write, 0=read
- cli_rmw  in  1  read-modify-write request
- cli_addr  in  ADDR_W  client address
- cli_wdata  in  DATA_W  client write data
- cli_mask  in  DATA_W  RMW bit mask (1 = take cli_wdata bit)
- cli_gnt  out  1  combinational accept strobe; command sampled this edge
- cli_rvalid  out  1  one-cycle pulse, cli_rdata valid
- cli_rdata  out  DATA_W  client read data
- cli_done  out  1  one-cycle pulse, write/RMW finished
- sram_addr  out  ADDR_W  registered
- sram_dout  out  DATA_W  registered write data
- sram_doe  out  1  data bus drive enable
- sram_din  in  DATA_W  data from pins
- sram_cen, sram_oen, sram_wen  out  1  active-low strobes, registered

## Operation
- States: IDLE, SCAN, RD_ADDR, RD_LATCH, WR_SETUP, WR_STROBE, WR_HOLD, TURN.
- IDLE: scan_gate=1 → SCAN (wins over simultaneous cli_req; no gnt). Else cli_req=1 → cli_gnt=1; read → RD_ADDR, write → WR_SETUP, rmw → RD_ADDR.
- SCAN: each cycle sram_addr<=scan_addr, oen=0, scan_data<=sram_din; scan_gate=0 → IDLE. cli_gnt never asserted in SCAN.
- RD_ADDR: addr driven, oen=0 → RD_LATCH. RD_LATCH: cli_rdata<=sram_din, cli_rvalid pulse; read → IDLE; rmw → WR_SETUP with write word (old & ~mask) | (wdata & mask).
- WR_SETUP: oen=1, doe=1, wen=1, data/addr stable → WR_STROBE for WR_CYCLES cycles (wen=0) → WR_HOLD (wen=1, doe=1, cli_done pulse) → TURN (doe=0, oen=1) → IDLE.
- Started client transactions always complete; scan_gate rising mid-transaction only raises scan_miss; scan_data holds last value.
- cen=0 in every state except IDLE.
- Reset (any time, mid-write included): state IDLE, cen/oen/wen=1, doe=0, sram_addr/sram_dout/scan_data/cli_rdata=0, gnt/rvalid/done/scan_miss=0.

## Timing
- Scan: scan_addr at edge n → on pins n+1 → scan_data valid after edge n+2; one-word-per-cycle throughput.
- Client read: gnt at cycle g → cli_rvalid at g+2.
- Write: gnt at g → wen low g+2 .. g+1+WR_CYCLES → cli_done at g+2+WR_CYCLES; next gnt earliest g+4+WR_CYCLES (after TURN).
- RMW: rvalid at g+2, done at g+4+WR_CYCLES.
- Never doe=1 and oen=0 in the same cycle; TURN guarantees one idle bus cycle after every write.

## Configuration
- VIDRAM_ARB_RMW_EN defined: cli_rmw enables the atomic read-merge-write path above; scan cannot intervene between read and write.
- Undefined: cli_rmw and cli_mask ignored; request decoded by cli_we only (rmw with we=1 is a plain write of cli_wdata, with we=0 a plain read).

## Test plan
- Reset mid-WR_STROBE → next cycle wen=1, doe=0, cen=1, no cli_done.
- scan_gate=1 with scan_addr 0,1,2… and SRAM model word=addr^16'hFFFF → scan_data 16'hFFFF, 16'hFFFE… two cycles behind, scan_miss=0.
- cli_req write addr 18'h12C00 data 16'h0A53 in blanking, WR_CYCLES=2 → wen low exactly 2 cycles, done at g+4, model holds 16'h0A53.
- cli_req and scan_gate rise same cycle → no gnt until scan_gate falls, then gnt, read returns stored value at g+2.
- scan_gate rises one cycle after write gnt → write completes, scan_miss high for 4+WR_CYCLES cycles, then SCAN.
- RMW_EN: old 16'h1234, mask 16'h00F0, wdata 16'h0070 → rdata 16'h1234, memory 16'h1274; without macro, cli_rmw=1, we=1 → memory 16'h0070.
